// File: rtl/racer_pkg.sv
// Shared definitions for the LED racer: screen codes, player indices,
// sequencer state encoding and small decode helpers.
package racer_pkg;

  localparam logic [1:0] SCREEN_MENU     = 2'b00;
  localparam logic [1:0] SCREEN_GAMEPLAY = 2'b01;
  localparam logic [1:0] SCREEN_FINISHED = 2'b10;

  localparam logic [1:0] PLAYER_GREEN  = 2'd0;
  localparam logic [1:0] PLAYER_RED    = 2'd1;
  localparam logic [1:0] PLAYER_BLUE   = 2'd2;
  localparam logic [1:0] PLAYER_YELLOW = 2'd3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_GAMEPLAY  = 2'd2;
  localparam logic [1:0] ST_FINISHED  = 2'd3;

  function automatic logic [1:0] screen_of(input logic [1:0] st);
    case (st)
      ST_GAMEPLAY: screen_of = SCREEN_GAMEPLAY;
      ST_FINISHED: screen_of = SCREEN_FINISHED;
      default:     screen_of = SCREEN_MENU;
    endcase
  endfunction

  // Bit 0 is green; lower index wins a simultaneous finish.
  function automatic logic [1:0] first_finisher(input logic [3:0] fin);
    if (fin[0])      first_finisher = PLAYER_GREEN;
    else if (fin[1]) first_finisher = PLAYER_RED;
    else if (fin[2]) first_finisher = PLAYER_BLUE;
    else             first_finisher = PLAYER_YELLOW;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step timer: pulses tick on the last count of each
// TICK_CYCLES-long period; clear restarts the period from zero.
module tick_prescaler #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/race_sequencer.sv
// Round life-cycle sequencer for the LED racer: menu, countdown, gameplay,
// finish hold. All outputs are registered from the next-state decision.
module race_sequencer
  import racer_pkg::*;
#(
  parameter int MAX_POS         = 109,
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int COUNTDOWN_START = 5,
  parameter int END_HOLD_TICKS  = 10,
  parameter int MIN_PLAYERS     = 1,
  localparam int PW = $clog2(MAX_POS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          green_ready_to_play,
  input  logic          red_ready_to_play,
  input  logic          blue_ready_to_play,
  input  logic          yellow_ready_to_play,
  input  logic [PW-1:0] green_cur_pos,
  input  logic [PW-1:0] red_cur_pos,
  input  logic [PW-1:0] blue_cur_pos,
  input  logic [PW-1:0] yellow_cur_pos,
  output logic [1:0]    current_screen,
  output logic [2:0]    countdown,
  output logic          game_running,
  output logic [1:0]    winner,
  output logic          winner_valid,
  output logic          new_round,
  output logic [1:0]    state_dbg
);

  localparam int HW = $clog2(END_HOLD_TICKS + 1);

  logic [1:0]    state, state_next;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    ready_cnt;
  logic          start_ok;
  logic [3:0]    fin;
  logic          tick;
  logic          hold_last;

  assign ready_cnt = {2'b0, green_ready_to_play} + {2'b0, red_ready_to_play}
                   + {2'b0, blue_ready_to_play}  + {2'b0, yellow_ready_to_play};
  assign start_ok  = (ready_cnt >= 3'(MIN_PLAYERS));

  // Out-of-range positions never equal the finish line, so they are inert.
  assign fin[0] = green_ready_to_play  && (green_cur_pos  == PW'(MAX_POS - 1));
  assign fin[1] = red_ready_to_play    && (red_cur_pos    == PW'(MAX_POS - 1));
  assign fin[2] = blue_ready_to_play   && (blue_cur_pos   == PW'(MAX_POS - 1));
  assign fin[3] = yellow_ready_to_play && (yellow_cur_pos == PW'(MAX_POS - 1));

  assign hold_last = (hold_cnt == HW'(END_HOLD_TICKS - 1));
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start_ok) state_next = ST_COUNTDOWN;
      ST_COUNTDOWN: begin
        if (!start_ok)                   state_next = ST_IDLE;
        else if (tick && countdown == 3'd1) state_next = ST_GAMEPLAY;
      end
      ST_GAMEPLAY:  if (|fin) state_next = ST_FINISHED;
      ST_FINISHED:  if (tick && hold_last) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (state_next != state),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      current_screen <= SCREEN_MENU;
      countdown      <= 3'd0;
      game_running   <= 1'b0;
      winner         <= 2'd0;
      winner_valid   <= 1'b0;
      new_round      <= 1'b0;
      hold_cnt       <= '0;
    end else begin
      state          <= state_next;
      current_screen <= screen_of(state_next);
      game_running   <= (state_next == ST_GAMEPLAY);
      new_round      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            countdown    <= 3'(COUNTDOWN_START);
            winner_valid <= 1'b0;
          end else begin
            countdown    <= 3'd0;
          end
        end
        ST_COUNTDOWN: begin
          // Abort takes precedence over a tick landing on the same cycle.
          if (!start_ok)  countdown <= 3'd0;
          else if (tick)  countdown <= countdown - 3'd1;
        end
        ST_GAMEPLAY: begin
          if (|fin) begin
            winner       <= first_finisher(fin);
            winner_valid <= 1'b1;
            hold_cnt     <= '0;
          end
        end
        ST_FINISHED: begin
          if (tick) begin
            if (hold_last) begin
              new_round <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              hold_cnt  <= hold_cnt + 1'b1;
            end
          end
        end
        default: countdown <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer: stimulus pushes the expected sequence of
// output snapshots and their hold lengths; a monitor checks every change.
module tb_race_sequencer;
  import racer_pkg::*;

  localparam int W  = 12;
  localparam int PW = $clog2(109);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          green_ready_to_play = 1'b0, red_ready_to_play = 1'b0;
  logic          blue_ready_to_play = 1'b0, yellow_ready_to_play = 1'b0;
  logic [PW-1:0] green_cur_pos = '0, red_cur_pos = '0, blue_cur_pos = '0, yellow_cur_pos = '0;
  logic [1:0]    current_screen;
  logic [2:0]    countdown;
  logic          game_running;
  logic [1:0]    winner;
  logic          winner_valid;
  logic          new_round;
  logic [1:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // snapshot = {state, screen, countdown, running, winner, winner_valid, new_round}
  logic [W-1:0] exp_q[$];
  int           len_q[$];
  string        name_q[$];

  race_sequencer #(
    .MAX_POS(109), .TICK_CYCLES(4), .COUNTDOWN_START(3),
    .END_HOLD_TICKS(2), .MIN_PLAYERS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .green_ready_to_play(green_ready_to_play), .red_ready_to_play(red_ready_to_play),
    .blue_ready_to_play(blue_ready_to_play), .yellow_ready_to_play(yellow_ready_to_play),
    .green_cur_pos(green_cur_pos), .red_cur_pos(red_cur_pos),
    .blue_cur_pos(blue_cur_pos), .yellow_cur_pos(yellow_cur_pos),
    .current_screen(current_screen), .countdown(countdown),
    .game_running(game_running), .winner(winner), .winner_valid(winner_valid),
    .new_round(new_round), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [1:0] scr,
                                      input logic [2:0] cd, input logic run,
                                      input logic [1:0] win, input logic wv, input logic nr);
    mk = {st, scr, cd, run, win, wv, nr};
  endfunction

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [W-1:0] v, input int len);
    name_q.push_back(n);
    exp_q.push_back(v);
    len_q.push_back(len);
  endtask

  task automatic check_int(input string n, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask

  // Scoreboard monitor: on every output change, close the previous segment
  // (length check) and compare the new snapshot with the next expectation.
  logic [W-1:0] cur;
  bit           started = 0;
  int           cyc = 0, seg_start = 0, pend_len = 0;
  string        pend_name = "";

  always @(negedge clk) begin
    logic [W-1:0] v;
    cyc++;
    v = {state_dbg, current_screen, countdown, game_running, winner, winner_valid, new_round};
    if (!started || v !== cur) begin
      if (started && pend_len != 0)
        check_int({pend_name, "_len"}, cyc - seg_start, pend_len);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", v, cyc);
        pend_len = 0;
        pend_name = "unexpected";
      end else begin
        logic [W-1:0] e;
        string        n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        pend_len = len_q.pop_front();
        pend_name = n;
        if (v !== e) begin
          tests_failed++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)", n, v, e, cyc);
        end
      end
      cur = v;
      seg_start = cyc;
      started = 1;
    end
  end

  // Stimulus
  initial begin
    push("reset", mk(ST_IDLE, SCREEN_MENU, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0), 0);
    step(2);
    rst = 1'b0;
    step(2);

    // Start, then abort while countdown shows 2
    push("cd3_a",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0), 4);
    push("cd2_a",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0), 1);
    push("abort",   mk(ST_IDLE,      SCREEN_MENU, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0), 3);
    green_ready_to_play = 1'b1;
    step(5);
    green_ready_to_play = 1'b0;
    step(3);

    // Full countdown into gameplay; blue sits beyond the finish line
    push("cd3_b",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0), 4);
    push("cd2_b",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0), 4);
    push("cd1_b",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0), 4);
    push("play_b",  mk(ST_GAMEPLAY,  SCREEN_GAMEPLAY, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0), 3);
    green_cur_pos = PW'(50);
    blue_cur_pos  = PW'(127);
    green_ready_to_play = 1'b1;
    red_ready_to_play = 1'b1;
    blue_ready_to_play = 1'b1;
    yellow_ready_to_play = 1'b1;
    step(15);

    // Red and yellow cross together: red wins on priority
    push("finished", mk(ST_FINISHED, SCREEN_FINISHED, 3'd0, 1'b0, 2'd1, 1'b1, 1'b0), 8);
    push("new_round", mk(ST_IDLE,    SCREEN_MENU, 3'd0, 1'b0, 2'd1, 1'b1, 1'b1), 1);
    push("idle_wv",  mk(ST_IDLE,     SCREEN_MENU, 3'd0, 1'b0, 2'd1, 1'b1, 1'b0), 3);
    red_cur_pos = PW'(108);
    yellow_cur_pos = PW'(108);
    step(1);
    green_ready_to_play = 1'b0;
    red_ready_to_play = 1'b0;
    blue_ready_to_play = 1'b0;
    yellow_ready_to_play = 1'b0;
    step(11);

    // Next round; stale finish-line positions without ready flags are inert
    push("cd3_c",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd3, 1'b0, 2'd1, 1'b0, 1'b0), 4);
    push("cd2_c",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd2, 1'b0, 2'd1, 1'b0, 1'b0), 4);
    push("cd1_c",   mk(ST_COUNTDOWN, SCREEN_MENU, 3'd1, 1'b0, 2'd1, 1'b0, 1'b0), 4);
    push("play_c",  mk(ST_GAMEPLAY,  SCREEN_GAMEPLAY, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0), 3);
    green_ready_to_play = 1'b1;
    step(15);

    // Mid-round reset: straight to IDLE, no new_round pulse
    push("mid_reset", mk(ST_IDLE, SCREEN_MENU, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0), 0);
    rst = 1'b1;
    green_ready_to_play = 1'b0;
    step(2);
    rst = 1'b0;
    step(8);

    check_int("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
